// File: rtl/hot_dec_pkg.sv
// Shared constants and state encoding for the 20-bit hot-vector decoder.
package hot_dec_pkg;

   localparam int HOT_WIDTH = 20;
   localparam int HOT_IDX_W = 5;
   localparam int HOT_CNT_W = 8;

   typedef enum logic {
      ST_ACCUM = 1'b0,
      ST_HOLD  = 1'b1
   } hot_dec_state_e;

endpackage : hot_dec_pkg

// File: rtl/onehot_decoder_5to20.sv
// Combinational index-to-one-hot leaf; flags indices that fall outside the vector.
import hot_dec_pkg::*;

module onehot_decoder_5to20 #(
   parameter int WIDTH = HOT_WIDTH,
   parameter int IDX_W = HOT_IDX_W
) (
   input  logic [IDX_W-1:0] idx_i,
   output logic [WIDTH-1:0] onehot_o,
   output logic             in_range_o
);

   always_comb begin
      // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
      onehot_o   = '0;
      in_range_o = (int'(idx_i) < WIDTH);
      for (int i = 0; i < WIDTH; i++) begin
         if (int'(idx_i) == i) onehot_o[i] = 1'b1;
      end
   end

endmodule : onehot_decoder_5to20

// File: rtl/hot_vector_decoder_20bit.sv
// Rebuilds a 20-bit hot vector from a stream of indices; frame closes on last_i.
// Optional duplicate-index flag dup_o is enabled by defining HOT_DEC_DUP_DET_EN.
import hot_dec_pkg::*;

module hot_vector_decoder_20bit #(
   parameter int WIDTH = HOT_WIDTH,
   parameter int IDX_W = HOT_IDX_W,
   parameter int CNT_W = HOT_CNT_W
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic [IDX_W-1:0] idx_i,
   input  logic             idx_valid_i,
   input  logic             last_i,
   output logic             idx_ready_o,
   output logic [WIDTH-1:0] hot_vector_o,
   output logic [CNT_W-1:0] evt_cnt_o,
   output logic             oor_o,
   output logic             vec_valid_o,
   input  logic             vec_ready_i
`ifdef HOT_DEC_DUP_DET_EN
   ,
   output logic             dup_o
`endif
);

   hot_dec_state_e   state_q;
   logic [WIDTH-1:0] acc_vec_q, acc_vec_d;
   logic [CNT_W-1:0] acc_cnt_q, acc_cnt_d;
   logic             acc_oor_q, acc_oor_d;
   logic [WIDTH-1:0] hot_vector_q;
   logic [CNT_W-1:0] evt_cnt_q;
   logic             oor_q;
   logic [WIDTH-1:0] idx_onehot;
   logic             idx_in_range;
   logic             beat_acc;

   onehot_decoder_5to20 #(
      .WIDTH (WIDTH),
      .IDX_W (IDX_W)
   ) u_onehot (
      .idx_i      (idx_i),
      .onehot_o   (idx_onehot),
      .in_range_o (idx_in_range)
   );

   assign idx_ready_o = (state_q == ST_ACCUM);
   assign beat_acc    = idx_valid_i & idx_ready_o;

   always_comb begin
      acc_vec_d = acc_vec_q | (idx_in_range ? idx_onehot : '0);
      acc_cnt_d = (acc_cnt_q == '1) ? acc_cnt_q : acc_cnt_q + 1'b1;
      acc_oor_d = acc_oor_q | ~idx_in_range;
   end

`ifdef HOT_DEC_DUP_DET_EN
   logic acc_dup_q, acc_dup_d, dup_q;

   // Out-of-range indices decode to all-zero, so they can never register a hit.
   assign acc_dup_d = acc_dup_q | (idx_in_range & |(acc_vec_q & idx_onehot));

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         acc_dup_q <= 1'b0;
         dup_q     <= 1'b0;
      end else if (beat_acc) begin
         acc_dup_q <= last_i ? 1'b0 : acc_dup_d;
         if (last_i) dup_q <= acc_dup_d;
      end
   end

   assign dup_o = dup_q;
`endif

   always_ff @(posedge clk_i or negedge rst_ni) begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      if (!rst_ni) begin
         state_q      <= ST_ACCUM;
         acc_vec_q    <= '0;
         acc_cnt_q    <= '0;
         acc_oor_q    <= 1'b0;
         hot_vector_q <= '0;
         evt_cnt_q    <= '0;
         oor_q        <= 1'b0;
      end else begin
         case (state_q)
            ST_ACCUM: begin
               if (beat_acc) begin
                  if (last_i) begin
                     hot_vector_q <= acc_vec_d;
                     evt_cnt_q    <= acc_cnt_d;
                     oor_q        <= acc_oor_d;
                     acc_vec_q    <= '0;
                     acc_cnt_q    <= '0;
                     acc_oor_q    <= 1'b0;
                     state_q      <= ST_HOLD;
                  end else begin
                     acc_vec_q <= acc_vec_d;
                     acc_cnt_q <= acc_cnt_d;
                     acc_oor_q <= acc_oor_d;
                  end
               end
            end
            ST_HOLD: begin
               if (vec_ready_i) state_q <= ST_ACCUM;
            end
            default: state_q <= ST_ACCUM;
         endcase
      end
   end

   assign vec_valid_o  = (state_q == ST_HOLD);
   assign hot_vector_o = hot_vector_q;
   assign evt_cnt_o    = evt_cnt_q;
   assign oor_o        = oor_q;

endmodule : hot_vector_decoder_20bit

// File: tb/tb_hot_vector_decoder_20bit.sv
// Directed self-checking bench for hot_vector_decoder_20bit (dup_o checked when HOT_DEC_DUP_DET_EN is defined).
module tb_hot_vector_decoder_20bit;

   logic        clk_i = 1'b0;
   logic        rst_ni;
   logic [4:0]  idx_i;
   logic        idx_valid_i;
   logic        last_i;
   logic        idx_ready_o;
   logic [19:0] hot_vector_o;
   logic [7:0]  evt_cnt_o;
   logic        oor_o;
   logic        vec_valid_o;
   logic        vec_ready_i;
`ifdef HOT_DEC_DUP_DET_EN
   logic        dup_o;
`endif

   int checks   = 0;
   int failures = 0;

   hot_vector_decoder_20bit dut (
      .clk_i        (clk_i),
      .rst_ni       (rst_ni),
      .idx_i        (idx_i),
      .idx_valid_i  (idx_valid_i),
      .last_i       (last_i),
      .idx_ready_o  (idx_ready_o),
      .hot_vector_o (hot_vector_o),
      .evt_cnt_o    (evt_cnt_o),
      .oor_o        (oor_o),
      .vec_valid_o  (vec_valid_o),
      .vec_ready_i  (vec_ready_i)
`ifdef HOT_DEC_DUP_DET_EN
      ,
      .dup_o        (dup_o)
`endif
   );

   always #5 clk_i = ~clk_i;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   // Inputs change and outputs are sampled 1 ns after the rising edge.
   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   task automatic beat(input logic [4:0] idx, input logic last);
      idx_valid_i = 1'b1;
      idx_i       = idx;
      last_i      = last;
      for (int w = 0; w < 50 && !idx_ready_o; w++) step();
      check("ready_wait", 32'(idx_ready_o), 32'd1);
      step();
      idx_valid_i = 1'b0;
      last_i      = 1'b0;
   endtask

   task automatic check_frame(input string tag, input logic [19:0] vec,
                              input logic [7:0] cnt, input logic oor);
      check({tag, "_valid"}, 32'(vec_valid_o),  32'd1);
      check({tag, "_vec"},   32'(hot_vector_o), 32'(vec));
      check({tag, "_cnt"},   32'(evt_cnt_o),    32'(cnt));
      check({tag, "_oor"},   32'(oor_o),        32'(oor));
   endtask

   initial begin
      rst_ni      = 1'b0;
      idx_i       = '0;
      idx_valid_i = 1'b0;
      last_i      = 1'b0;
      vec_ready_i = 1'b1;
      step();
      step();
      check("rst_ready", 32'(idx_ready_o), 32'd1);
      check("rst_valid", 32'(vec_valid_o), 32'd0);
      rst_ni = 1'b1;
      step();

      // Reset in the middle of a partial frame discards it.
      beat(5'd3, 1'b0);
      beat(5'd7, 1'b0);
      rst_ni = 1'b0;
      #1;
      check("midrst_vec",   32'(hot_vector_o), 32'h0);
      check("midrst_cnt",   32'(evt_cnt_o),    32'h0);
      check("midrst_oor",   32'(oor_o),        32'h0);
      check("midrst_valid", 32'(vec_valid_o),  32'h0);
      check("midrst_ready", 32'(idx_ready_o),  32'h1);
`ifdef HOT_DEC_DUP_DET_EN
      check("midrst_dup",   32'(dup_o),        32'h0);
`endif
      step();
      rst_ni = 1'b1;
      step();
      beat(5'd5, 1'b1);
      check_frame("postrst", 20'h00020, 8'd1, 1'b0);
      step();

      // Multi-beat frame with ready held high: valid for exactly one cycle.
      beat(5'd0, 1'b0);
      beat(5'd19, 1'b0);
      check("accum_valid", 32'(vec_valid_o), 32'd0);
      beat(5'd4, 1'b1);
      check_frame("multi", 20'h80011, 8'd3, 1'b0);
`ifdef HOT_DEC_DUP_DET_EN
      check("multi_dup", 32'(dup_o), 32'd0);
`endif
      step();
      check("multi_valid_drop", 32'(vec_valid_o), 32'd0);
      check("multi_ready_back", 32'(idx_ready_o), 32'd1);

      // Out-of-range and duplicate index.
      beat(5'd2, 1'b0);
      beat(5'd25, 1'b0);
      beat(5'd2, 1'b1);
      check_frame("oor_dup", 20'h00004, 8'd3, 1'b1);
`ifdef HOT_DEC_DUP_DET_EN
      check("oor_dup_dup", 32'(dup_o), 32'd1);
`endif
      step();

      // Boundary indices: 20 is first out-of-range, 31 is the maximum; repeated oor is not a dup.
      beat(5'd20, 1'b0);
      beat(5'd31, 1'b1);
      check_frame("idx_20_31", 20'h00000, 8'd2, 1'b1);
`ifdef HOT_DEC_DUP_DET_EN
      check("idx_20_31_dup", 32'(dup_o), 32'd0);
`endif
      step();
      beat(5'd19, 1'b1);
      check_frame("idx_19", 20'h80000, 8'd1, 1'b0);
      step();

      // Backpressure: frame held while the next beat waits.
      vec_ready_i = 1'b0;
      beat(5'd10, 1'b1);
      idx_valid_i = 1'b1;
      idx_i       = 5'd12;
      last_i      = 1'b1;
      for (int c = 0; c < 5; c++) begin
         check("bp_ready", 32'(idx_ready_o),  32'd0);
         check("bp_valid", 32'(vec_valid_o),  32'd1);
         check("bp_vec",   32'(hot_vector_o), 32'h00400);
         check("bp_cnt",   32'(evt_cnt_o),    32'd1);
         step();
      end
      vec_ready_i = 1'b1;
      step();
      check("bp_release_valid", 32'(vec_valid_o), 32'd0);
      check("bp_release_ready", 32'(idx_ready_o), 32'd1);
      step();
      idx_valid_i = 1'b0;
      last_i      = 1'b0;
      check_frame("bp_held", 20'h01000, 8'd1, 1'b0);
      step();

      // Counter saturation at 255.
      for (int n = 0; n < 300; n++) beat(5'd1, 1'b0);
      beat(5'd1, 1'b1);
      check_frame("sat", 20'h00002, 8'd255, 1'b0);
`ifdef HOT_DEC_DUP_DET_EN
      check("sat_dup", 32'(dup_o), 32'd1);
`endif
      step();

      // Back-to-back single-beat frames.
      beat(5'd3, 1'b1);
      check_frame("b2b_first", 20'h00008, 8'd1, 1'b0);
      beat(5'd7, 1'b1);
      check_frame("b2b_second", 20'h00080, 8'd1, 1'b0);
      step();
      check("b2b_done_valid", 32'(vec_valid_o), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule : tb_hot_vector_decoder_20bit

// File: doc/hot_vector_decoder_20bit.md
Name: hot_vector_decoder_20bit

Overview:
- Inverse of the 20-bit priority-encoder path: consumes a stream of 5-bit indices and rebuilds a 20-bit hot vector.
- Indices arrive one per beat over a valid/ready handshake and are OR-accumulated into a frame.
- A beat flagged last_i closes the frame. The frame is then presented over a second valid/ready handshake.
- Sits downstream of the index serializer, feeding the vector-side consumer (e.g. spike/event map logic).

Parameters:
- WIDTH, 20: hot vector width; legal indices are 0..WIDTH-1.
- IDX_W, 5: index width; must satisfy 2**IDX_W >= WIDTH.
- CNT_W, 8: width of the per-frame accepted-beat counter (saturating).

Ports:
- clk_i  in  1  clock, rising edge.
- rst_ni  in  1  asynchronous active-low reset.
- idx_i  in  IDX_W  index to set.
- idx_valid_i  in  1  index beat valid.
- last_i  in  1  beat closes the frame; qualified by idx_valid_i.
- idx_ready_o  out  1  decoder accepts a beat this cycle.
- hot_vector_o  out  WIDTH  completed frame vector.
- evt_cnt_o  out  CNT_W  accepted beats in frame, saturating at 2**CNT_W-1.
- oor_o  out  1  frame contained at least one index >= WIDTH.
- vec_valid_o  out  1  frame outputs valid.
- vec_ready_i  in  1  consumer takes the frame.

Behaviour:
- Reset (async assert, sync-safe release): state=ACCUM.
  - Accumulators and all outputs are 0, except idx_ready_o=1 (combinational from state).
- States: ACCUM and HOLD.
- ACCUM:
  - idx_ready_o=1, vec_valid_o=0.
  - A beat is accepted on a clock edge where idx_valid_i & idx_ready_o.
  - Accepted beat effects:
    - acc_vec |= onehot(idx_i) if idx_i < WIDTH; otherwise acc_vec is unchanged and acc_oor is set.
    - acc_cnt increments, saturating.
  - Accepted beat with last_i=1, same edge:
    - hot_vector_o, evt_cnt_o and oor_o load the accumulated values including this beat.
    - vec_valid_o goes to 1 and state goes to HOLD.
    - Accumulators clear to 0.
- HOLD:
  - idx_ready_o=0 and vec_valid_o=1.
  - Outputs are stable until vec_ready_i=1 at a clock edge; state then returns to ACCUM and vec_valid_o goes to 0.
  - Output registers keep their last values after the handshake; they are don't-care while vec_valid_o=0.
- Latency: last beat accepted at edge N means vec_valid_o is high in cycle N+1.
- Throughput: a k-beat frame occupies k+1 cycles minimum when vec_ready_i is held high.
- Duplicate index in a frame: the bit is already set, so no change to the vector; it is still counted.
- Index 31 (or any value in 20..31): counted and flags oor_o; no vector bit is set.
- A single-beat frame (first beat carries last_i) is legal.
- Empty frames cannot be produced.
- idx_valid_i during HOLD is ignored; the source must hold the beat (ready=0).
- Counter saturation: evt_cnt_o stays at 255 for frames of 255 or more beats.
- Reset mid-frame or mid-HOLD: the partial frame is discarded and the pending vector is lost. Output is all-zero with state=ACCUM.
- No combinational path from idx_valid_i to idx_ready_o.
- Combinational path from vec_ready_i: none; it only takes effect at the clock edge.

Optional Feature:
- Macro HOT_DEC_DUP_DET_EN.
- Defined:
  - Adds output dup_o (1 bit, reset 0), loaded with the frame like oor_o.
  - dup_o=1 if any accepted in-range index hit an already-set bit within the frame.
  - Out-of-range repeats do not set dup_o.
- Undefined:
  - Port and logic are absent.
  - All other behaviour is identical.

Decomposition:
- Package hot_dec_pkg holds:
  - Constants HOT_WIDTH=20, HOT_IDX_W=5, HOT_CNT_W=8.
  - State enum hot_dec_state_e {ST_ACCUM, ST_HOLD}.
- Sub-module onehot_decoder_5to20 (combinational) maps idx to a WIDTH-bit one-hot plus an in_range flag.
  - It is the inverse counterpart of the 4-bit/5-bit encoder leaves and is reused for the accumulate and duplicate checks.

Test Plan:
- Reset: rst_ni low mid-frame after beats 3,7 → all outputs 0 and idx_ready_o=1; after release, frame {5,last} gives hot_vector_o=0x00020, evt_cnt_o=1.
- Multi-beat: beats 0, 19, 4 (last on 4), vec_ready_i=1 → hot_vector_o=0x80011, evt_cnt_o=3, oor_o=0, vec_valid_o for exactly 1 cycle, idx_ready_o back high the next cycle.
- Out-of-range and duplicate: beats 2, 25, 2(last) → hot_vector_o=0x00004, evt_cnt_o=3, oor_o=1; with HOT_DEC_DUP_DET_EN, dup_o=1.
- Backpressure: frame {10,last}, vec_ready_i=0 for 5 cycles while idx_valid_i=1 → idx_ready_o=0, outputs stable at 0x00400; the held beat is accepted only after the handshake.
- Saturation: 300 beats of index 1 then last → evt_cnt_o=255, hot_vector_o=0x00002.
- Back-to-back: frames {3,last} and {7,last} streamed with vec_ready_i=1 → vectors 0x00008 then 0x00080; the second frame is not polluted by the first.
